// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: stall/flush/bubble handling plus the multi-cycle
// madd/msub feedback state. Define EX_MEM_PERF_EN to add the bubble_cnt counter.
module ex_mem_pipe #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 5,
   parameter int                CNT_W    = 2,
   parameter logic [ADDR_W-1:0] NOP_ADDR = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_ex,
   input  logic                stall_mem,
   input  logic                flush,
   input  logic                ex_valid,
   input  logic [DATA_W-1:0]   ex_wdata,
   input  logic [ADDR_W-1:0]   ex_wd,
   input  logic                ex_wreg,
   input  logic [DATA_W-1:0]   ex_hi,
   input  logic [DATA_W-1:0]   ex_lo,
   input  logic                ex_whilo,
   input  logic [2*DATA_W-1:0] ex_hilo_temp,
   input  logic [CNT_W-1:0]    ex_cnt,
   output logic                mem_valid,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [ADDR_W-1:0]   mem_wd,
   output logic                mem_wreg,
   output logic [DATA_W-1:0]   mem_hi,
   output logic [DATA_W-1:0]   mem_lo,
   output logic                mem_whilo,
   output logic [2*DATA_W-1:0] hilo_temp_o,
`ifdef EX_MEM_PERF_EN
   output logic [15:0]         bubble_cnt,
`endif
   output logic [CNT_W-1:0]    cnt_o
);

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] wdata;
      logic [ADDR_W-1:0] wd;
      logic              wreg;
      logic [DATA_W-1:0] hi;
      logic [DATA_W-1:0] lo;
      logic              whilo;
   } stage_t;

   stage_t              stage_d, stage_q;
   stage_t              ex_stage, bubble_stage;
   logic [2*DATA_W-1:0] hilo_d, hilo_q;
   logic [CNT_W-1:0]    cnt_d, cnt_q;
   logic                bubble_ins;

   always_comb begin
      ex_stage       = '0;
      ex_stage.valid = ex_valid;
      ex_stage.wdata = ex_wdata;
      ex_stage.wd    = ex_wd;
      ex_stage.wreg  = ex_wreg;
      ex_stage.hi    = ex_hi;
      ex_stage.lo    = ex_lo;
      ex_stage.whilo = ex_whilo;

      // A bubble carries no write so forwarding downstream sees nothing.
      bubble_stage    = '0;
      bubble_stage.wd = NOP_ADDR;
   end

   // Priority: flush, EX-only stall (bubble + capture), advance, full hold.
   // stall_ex=0 with stall_mem=1 is not expected and simply advances.
   always_comb begin
      stage_d    = stage_q;
      hilo_d     = hilo_q;
      cnt_d      = cnt_q;
      bubble_ins = 1'b0;
      if (flush) begin
         stage_d    = bubble_stage;
         hilo_d     = '0;
         cnt_d      = '0;
         bubble_ins = 1'b1;
      end else if (stall_ex && !stall_mem) begin
         stage_d    = bubble_stage;
         hilo_d     = ex_hilo_temp;
         cnt_d      = ex_cnt;
         bubble_ins = 1'b1;
      end else if (!stall_ex) begin
         stage_d = ex_stage;
         hilo_d  = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stage_q <= bubble_stage;
         hilo_q  <= '0;
         cnt_q   <= '0;
      end else begin
         stage_q <= stage_d;
         hilo_q  <= hilo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_valid   = stage_q.valid;
   assign mem_wdata   = stage_q.wdata;
   assign mem_wd      = stage_q.wd;
   assign mem_wreg    = stage_q.wreg;
   assign mem_hi      = stage_q.hi;
   assign mem_lo      = stage_q.lo;
   assign mem_whilo   = stage_q.whilo;
   assign hilo_temp_o = hilo_q;
   assign cnt_o       = cnt_q;

`ifdef EX_MEM_PERF_EN
   logic [15:0] bubble_cnt_d, bubble_cnt_q;

   // Saturating; deliberately survives flush so it spans exception recovery.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_ins && bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bubble_cnt_q <= '0;
      else      bubble_cnt_q <= bubble_cnt_d;
   end

   assign bubble_cnt = bubble_cnt_q;
`else
   logic unused_bubble;
   assign unused_bubble = bubble_ins;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed scoreboard bench for ex_mem_pipe; perf checks build when
// EX_MEM_PERF_EN is defined.
module tb_ex_mem_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_ex, stall_mem, flush;
   logic        ex_valid, ex_wreg, ex_whilo;
   logic [31:0] ex_wdata, ex_hi, ex_lo;
   logic [4:0]  ex_wd;
   logic [63:0] ex_hilo_temp;
   logic [1:0]  ex_cnt;
   logic        mem_valid, mem_wreg, mem_whilo;
   logic [31:0] mem_wdata, mem_hi, mem_lo;
   logic [4:0]  mem_wd;
   logic [63:0] hilo_temp_o;
   logic [1:0]  cnt_o;
`ifdef EX_MEM_PERF_EN
   logic [15:0] bubble_cnt;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic        valid;
      logic [31:0] wdata;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        whilo;
      logic [63:0] hilo;
      logic [1:0]  cnt;
   } exp_t;

   exp_t sb[$];

   ex_mem_pipe dut (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
      .ex_valid(ex_valid), .ex_wdata(ex_wdata), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
      .ex_hilo_temp(ex_hilo_temp), .ex_cnt(ex_cnt),
      .mem_valid(mem_valid), .mem_wdata(mem_wdata), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
      .hilo_temp_o(hilo_temp_o),
`ifdef EX_MEM_PERF_EN
      .bubble_cnt(bubble_cnt),
`endif
      .cnt_o(cnt_o)
   );

   always #5 clk = ~clk;

   // The illegal stall combination must never be driven.
   always @(posedge clk) begin
      if (rst && !stall_ex && stall_mem) begin
         tests++;
         fails++;
         $display("FAIL illegal_stall got=stall_ex0/stall_mem1 exp=never");
      end
   end

   function automatic exp_t mk(input logic v, input logic [31:0] wdata, input logic [4:0] wd,
                               input logic wreg, input logic [31:0] hi, input logic [31:0] lo,
                               input logic whilo, input logic [63:0] hilo, input logic [1:0] cnt);
      exp_t e;
      e = '{valid:v, wdata:wdata, wd:wd, wreg:wreg, hi:hi, lo:lo, whilo:whilo, hilo:hilo, cnt:cnt};
      return e;
   endfunction

   function automatic exp_t observe();
      return mk(mem_valid, mem_wdata, mem_wd, mem_wreg, mem_hi, mem_lo, mem_whilo, hilo_temp_o, cnt_o);
   endfunction

   task automatic set_ex(input logic v, input logic [31:0] wdata, input logic [4:0] wd,
                         input logic wreg, input logic [31:0] hi, input logic [31:0] lo,
                         input logic whilo, input logic [63:0] hilo, input logic [1:0] cnt);
      ex_valid = v; ex_wdata = wdata; ex_wd = wd; ex_wreg = wreg;
      ex_hi = hi; ex_lo = lo; ex_whilo = whilo; ex_hilo_temp = hilo; ex_cnt = cnt;
   endtask

   task automatic set_ctl(input logic sx, input logic sm, input logic fl);
      stall_ex = sx; stall_mem = sm; flush = fl;
   endtask

   task automatic compare(input string tag);
      exp_t e, o;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL %s got=empty_scoreboard exp=entry", tag);
      end else begin
         e = sb.pop_front();
         o = observe();
         assert (o === e) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, o, e);
         end
      end
   endtask

   // Advance one edge and check what the DUT registered.
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic idle_cycles(input int n, input logic sx, input logic sm, input logic fl);
      set_ctl(sx, sm, fl);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] MADD1 = 64'h0000_0001_0000_0002;
   localparam logic [63:0] MADD2 = 64'h0000_0003_0000_0005;

   initial begin
      rst = 1'b0;
      set_ctl(0, 0, 0);
      set_ex(1, 32'hFFFF_FFFF, 5'd7, 1, 32'h1, 32'h2, 1, 64'hFF, 2'd3);
      #2;
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      compare("reset_init");

      @(negedge clk);
      rst = 1'b1;
      #1;

      // Pass-through patterns
      set_ex(1, 32'hDEAD_BEEF, 5'd9, 1, 0, 0, 0, 64'hAAAA, 2'd2);
      sb.push_back(mk(1, 32'hDEAD_BEEF, 5'd9, 1, 0, 0, 0, 0, 0));
      tick("pass_deadbeef");

      set_ex(1, 32'hA5A5_0F0F, 5'd31, 0, 32'h1111_2222, 32'h3333_4444, 1, 0, 0);
      sb.push_back(mk(1, 32'hA5A5_0F0F, 5'd31, 0, 32'h1111_2222, 32'h3333_4444, 1, 0, 0));
      tick("pass_hilo");

      set_ex(0, 32'h0000_0055, 5'd1, 1, 0, 0, 0, 0, 0);
      sb.push_back(mk(0, 32'h0000_0055, 5'd1, 1, 0, 0, 0, 0, 0));
      tick("pass_invalid");

      // Multi-cycle madd: EX stalled, MEM running
      set_ctl(1, 0, 0);
      set_ex(1, 32'h77, 5'd3, 1, 32'hCAFE_0001, 32'hBEEF_0002, 1, MADD1, 2'd1);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, MADD1, 2'd1));
      tick("madd_step1");

      set_ex(1, 32'h77, 5'd3, 1, 32'hCAFE_0001, 32'hBEEF_0002, 1, MADD2, 2'd2);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, MADD2, 2'd2));
      tick("madd_step2");

      set_ctl(0, 0, 0);
      sb.push_back(mk(1, 32'h77, 5'd3, 1, 32'hCAFE_0001, 32'hBEEF_0002, 1, 0, 0));
      tick("madd_release");

      // Full stall hold
      set_ex(1, 32'h1234_5678, 5'd4, 1, 32'h9, 32'h8, 0, 0, 0);
      sb.push_back(mk(1, 32'h1234_5678, 5'd4, 1, 32'h9, 32'h8, 0, 0, 0));
      tick("hold_load");
      set_ctl(1, 1, 0);
      set_ex(0, 32'hFFFF_0000, 5'd20, 0, 32'h5, 32'h6, 1, MADD2, 2'd3);
      for (int i = 0; i < 3; i++) begin
         sb.push_back(mk(1, 32'h1234_5678, 5'd4, 1, 32'h9, 32'h8, 0, 0, 0));
         tick("hold_stall");
      end

      // Feedback state must also be held during a full stall
      set_ctl(1, 0, 0);
      set_ex(1, 32'h1, 5'd2, 1, 0, 0, 0, MADD1, 2'd3);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, MADD1, 2'd3));
      tick("capture_cnt3");
      set_ctl(1, 1, 0);
      set_ex(1, 32'h1, 5'd2, 1, 0, 0, 0, MADD2, 2'd0);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, MADD1, 2'd3));
      tick("hold_feedback");

      // Flush overrides stalls and clears feedback
      set_ctl(1, 1, 1);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick("flush_full_stall");

      set_ctl(0, 0, 0);
      set_ex(1, 32'hBBBB_CCCC, 5'd12, 1, 32'h1, 32'h2, 1, 0, 0);
      sb.push_back(mk(1, 32'hBBBB_CCCC, 5'd12, 1, 32'h1, 32'h2, 1, 0, 0));
      tick("pre_flush_load");
      set_ctl(0, 0, 1);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      tick("flush_no_stall");

      // Asynchronous reset mid multi-cycle op
      set_ctl(1, 0, 0);
      set_ex(1, 32'h5, 5'd6, 1, 0, 0, 1, MADD2, 2'd2);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, MADD2, 2'd2));
      tick("pre_reset_capture");
      set_ctl(0, 0, 0);
      sb.push_back(mk(1, 32'h5, 5'd6, 1, 0, 0, 1, 0, 0));
      tick("pre_reset_load");
      #2;
      rst = 1'b0;
      #1;
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      compare("reset_async");
      @(negedge clk);
      rst = 1'b1;
      set_ctl(1, 0, 0);
      set_ex(1, 32'h5, 5'd6, 1, 0, 0, 1, MADD1, 2'd1);
      sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, MADD1, 2'd1));
      tick("restart_after_reset");

`ifdef EX_MEM_PERF_EN
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      assert (bubble_cnt === 16'd0) else begin
         fails++; $error("FAIL perf_reset got=%h exp=%h", bubble_cnt, 16'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(5, 1, 0, 0);
      idle_cycles(2, 1, 1, 0);
      idle_cycles(2, 0, 0, 1);
      idle_cycles(3, 0, 0, 0);
      tests++;
      assert (bubble_cnt === 16'd7) else begin
         fails++; $error("FAIL perf_count7 got=%h exp=%h", bubble_cnt, 16'd7);
      end
      idle_cycles(65534 - 7, 1, 0, 0);
      tests++;
      assert (bubble_cnt === 16'hFFFE) else begin
         fails++; $error("FAIL perf_preload got=%h exp=%h", bubble_cnt, 16'hFFFE);
      end
      idle_cycles(3, 1, 0, 0);
      tests++;
      assert (bubble_cnt === 16'hFFFF) else begin
         fails++; $error("FAIL perf_saturate got=%h exp=%h", bubble_cnt, 16'hFFFF);
      end
      set_ctl(0, 0, 0);
`endif

      tests++;
      assert (sb.size() == 0) else begin
         fails++; $error("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
